// File: rtl/biu_pkg.sv
// rtl/biu_pkg.sv - shared width and FSM encoding for the bus interface unit
package biu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

endpackage

// File: rtl/biu.sv
// rtl/biu.sv - arbitrates fetch and load/store ports onto a single-outstanding memory bus
module biu #(
  parameter int XLEN = biu_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_rd,
  input  logic [XLEN-1:0]   if_addr,
  output logic [31:0]       if_data,
  output logic              b_rd_i,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic [XLEN-1:0]   d_rdata,
  output logic              b_rd,
  output logic              b_wr,
  output logic              m_req,
  output logic              m_we,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_be,
  input  logic              m_ack,
  input  logic [XLEN-1:0]   m_rdata
);
  import biu_pkg::*;

  state_t state_q, state_d;
  logic   done_i, done_d;
  logic   fetch_hi;
  logic   ack;
  logic   pend_i, pend_d;
  logic   issue;

  // An ack only counts while a request is actually on the bus.
  assign ack    = m_ack & m_req;
  assign pend_i = if_rd & ~done_i;
  assign pend_d = (d_rd | d_wr) & ~done_d;

  assign b_rd_i = rst_n & if_rd & ~done_i;
  assign b_rd   = rst_n & d_rd & ~done_d;
  assign b_wr   = rst_n & d_wr & ~done_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_d)      state_d = d_wr ? ST_STORE : ST_LOAD;
        else if (pend_i) state_d = ST_FETCH;
      end
      default: begin
        if (ack) state_d = ST_IDLE;
      end
    endcase
  end

  assign issue = (state_q == ST_IDLE) && (state_d != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      fetch_hi <= 1'b0;
      done_i   <= 1'b0;
      done_d   <= 1'b0;
      if_data  <= '0;
      d_rdata  <= '0;
    end else begin
      state_q <= state_d;

      if (issue) begin
        m_req    <= 1'b1;
        m_we     <= (state_d == ST_STORE);
        m_addr   <= (state_d == ST_FETCH) ? (if_addr & {{(XLEN-3){1'b1}}, 3'b000}) : d_addr;
        m_wdata  <= d_wdata;
        m_be     <= (state_d == ST_STORE) ? d_be : '1;
        fetch_hi <= if_addr[2];
      end else if (ack) begin
        m_req <= 1'b0;
        m_we  <= 1'b0;
      end

      if (ack && state_q == ST_FETCH) if_data <= fetch_hi ? m_rdata[63:32] : m_rdata[31:0];
      if (ack && state_q == ST_LOAD)  d_rdata <= m_rdata;

      // Flags clear once the pipeline advances; a completion in the same edge still wins.
      if (!b_rd_i && !b_rd && !b_wr) begin
        done_i <= 1'b0;
        done_d <= 1'b0;
      end
      // A port that dropped its request mid-transaction gets no done flag.
      if (ack && state_q == ST_FETCH && if_rd) done_i <= 1'b1;
      if (ack && (state_q == ST_LOAD || state_q == ST_STORE) && (d_rd || d_wr)) done_d <= 1'b1;
    end
  end

endmodule

// File: tb/tb_biu.sv
// tb/tb_biu.sv - scoreboard bench for biu with a latency-programmable memory model
module tb_biu;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_rd;
  logic [XLEN-1:0] if_addr;
  logic [31:0]     if_data;
  logic            b_rd_i;
  logic            d_rd, d_wr;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic [7:0]      d_be;
  logic            b_rd, b_wr;
  logic            m_req, m_we;
  logic [XLEN-1:0] m_addr, m_wdata;
  logic [7:0]      m_be;
  logic            m_ack;
  logic [XLEN-1:0] m_rdata;

  always #5 clk = ~clk;

  biu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_rd(if_rd), .if_addr(if_addr), .if_data(if_data), .b_rd_i(b_rd_i),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .b_rd(b_rd), .b_wr(b_wr),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_if[$];
  logic [63:0] exp_ld[$];
  logic [63:0] mem [logic [63:0]];

  int checks = 0;
  int errors = 0;
  int lat = 1;
  bit mem_auto = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_mem(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Memory: acks in the lat-th cycle of each request.
  initial begin : memory
    int cnt;
    cnt = 0;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      m_ack = 1'b0;
      if (mem_auto && m_req) begin
        cnt++;
        if (cnt == lat) begin
          m_ack = 1'b1;
          m_rdata = rd_mem(m_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  logic prev_req = 1'b0, prev_bri = 1'b0, prev_brd = 1'b0;
  bit   have_cur = 1'b0;
  req_t cur;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #3;
      if (m_req && !prev_req) begin
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got request addr %h, expected none", m_addr);
          have_cur = 1'b0;
        end else begin
          cur = exp_req.pop_front();
          have_cur = 1'b1;
          chk("req_we", 64'(m_we), 64'(cur.kind == 2));
          chk("req_addr", m_addr, cur.addr);
          if (cur.kind == 2) begin
            chk("req_wdata", m_wdata, cur.wdata);
            chk("req_be", 64'(m_be), 64'(cur.be));
          end else if (cur.kind == 1) begin
            chk("req_be_load", 64'(m_be), 64'hFF);
          end
        end
      end else if (m_req && prev_req && have_cur) begin
        chk("hold_addr", m_addr, cur.addr);
        chk("hold_we", 64'(m_we), 64'(cur.kind == 2));
        if (cur.kind == 2) begin
          chk("hold_wdata", m_wdata, cur.wdata);
          chk("hold_be", 64'(m_be), 64'(cur.be));
        end
      end
      if (rst_n && if_rd && prev_bri && !b_rd_i) begin
        if (exp_if.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_done_unexpected: got if_data %h, expected no completion", if_data);
        end else chk("if_data", 64'(if_data), 64'(exp_if.pop_front()));
      end
      if (rst_n && d_rd && prev_brd && !b_rd) begin
        if (exp_ld.size() == 0) begin
          checks++; errors++;
          $display("FAIL load_done_unexpected: got d_rdata %h, expected no completion", d_rdata);
        end else chk("d_rdata", d_rdata, exp_ld.pop_front());
      end
      prev_req = m_req;
      prev_bri = b_rd_i;
      prev_brd = b_rd;
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    rst_n = 1'b0; if_rd = 1'b1; if_addr = '0;
    d_rd = 1'b1; d_wr = 1'b1; d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (2) @(negedge clk);
    chk("rst_m_req", 64'(m_req), 0);
    chk("rst_m_we", 64'(m_we), 0);
    chk("rst_if_data", 64'(if_data), 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_b_rd_i", 64'(b_rd_i), 0);
    chk("rst_b_rd", 64'(b_rd), 0);
    chk("rst_b_wr", 64'(b_wr), 0);
    if_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait fetch, upper word.
    mem[64'h1000] = 64'hAAAA_BBBB_0000_0013;
    lat = 1;
    exp_req.push_back('{0, 64'h1000, 64'h0, 8'h0});
    exp_if.push_back(32'hAAAABBBB);
    if_rd = 1'b1; if_addr = 64'h1004;
    @(negedge clk);
    chk("t1_m_req_c1", 64'(m_req), 1);
    chk("t1_busy_c1", 64'(b_rd_i), 1);
    @(negedge clk);
    chk("t1_m_req_c2", 64'(m_req), 0);
    chk("t1_busy_c2", 64'(b_rd_i), 0);
    chk("t1_if_data", 64'(if_data), 64'hAAAABBBB);
    if_rd = 1'b0;
    repeat (2) @(negedge clk);

    // Fetch and load together, 3-cycle memory: load first.
    lat = 3;
    mem[64'h3000] = 64'h0123_4567_89AB_CDEF;
    mem[64'h1008] = 64'hDEAD_BEEF_CAFE_F00D;
    exp_req.push_back('{1, 64'h3000, 64'h0, 8'hFF});
    exp_req.push_back('{0, 64'h1008, 64'h0, 8'h0});
    exp_ld.push_back(64'h0123_4567_89AB_CDEF);
    exp_if.push_back(32'hCAFEF00D);
    if_rd = 1'b1; if_addr = 64'h1008; d_rd = 1'b1; d_addr = 64'h3000;
    #1;
    for (int k = 0; k < 40 && b_rd; k++) @(negedge clk);
    chk("t2_load_done", 64'(b_rd), 0);
    chk("t2_fetch_pending", 64'(b_rd_i), 1);
    for (int k = 0; k < 40 && b_rd_i; k++) @(negedge clk);
    chk("t2_fetch_done", 64'(b_rd_i), 0);
    chk("t2_load_still_done", 64'(b_rd), 0);
    if_rd = 1'b0; d_rd = 1'b0;
    repeat (2) @(negedge clk);

    // Store with payload held while inputs change.
    lat = 2;
    exp_req.push_back('{2, 64'h2000, 64'h1122_3344_5566_7788, 8'h0F});
    d_wr = 1'b1; d_addr = 64'h2000; d_be = 8'h0F; d_wdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    chk("t3_m_req", 64'(m_req), 1);
    chk("t3_m_we", 64'(m_we), 1);
    chk("t3_m_be", 64'(m_be), 64'h0F);
    chk("t3_b_wr_c1", 64'(b_wr), 1);
    d_wdata = '0; d_be = 8'hFF;
    @(negedge clk);
    chk("t3_b_wr_c2", 64'(b_wr), 1);
    chk("t3_m_req_c2", 64'(m_req), 1);
    @(negedge clk);
    chk("t3_b_wr_done", 64'(b_wr), 0);
    chk("t3_m_req_done", 64'(m_req), 0);
    d_wr = 1'b0;
    repeat (2) @(negedge clk);

    // Fetch finishes while load pending: no re-fetch until all busy low.
    lat = 3;
    mem[64'h1010] = 64'h1111_2222_3333_4444;
    mem[64'h3008] = 64'h5555_6666_7777_8888;
    exp_req.push_back('{0, 64'h1010, 64'h0, 8'h0});
    exp_req.push_back('{1, 64'h3008, 64'h0, 8'hFF});
    exp_req.push_back('{0, 64'h1010, 64'h0, 8'h0});
    exp_if.push_back(32'h33334444);
    exp_if.push_back(32'h33334444);
    exp_ld.push_back(64'h5555_6666_7777_8888);
    if_rd = 1'b1; if_addr = 64'h1010;
    @(negedge clk);
    d_rd = 1'b1; d_addr = 64'h3008;
    #1;
    for (int k = 0; k < 40 && b_rd_i; k++) @(negedge clk);
    chk("t4_fetch_done", 64'(b_rd_i), 0);
    chk("t4_load_busy", 64'(b_rd), 1);
    for (int k = 0; k < 40 && b_rd; k++) @(negedge clk);
    chk("t4_load_done", 64'(b_rd), 0);
    chk("t4_fetch_held_done", 64'(b_rd_i), 0);
    d_rd = 1'b0;
    @(negedge clk);
    chk("t4_refetch_busy", 64'(b_rd_i), 1);
    for (int k = 0; k < 40 && b_rd_i; k++) @(negedge clk);
    chk("t4_refetch_done", 64'(b_rd_i), 0);
    if_rd = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during a load, then a late ack.
    mem_auto = 1'b0;
    exp_req.push_back('{1, 64'h3000, 64'h0, 8'hFF});
    d_rd = 1'b1; d_addr = 64'h3000;
    @(negedge clk);
    chk("t5_m_req", 64'(m_req), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_m_req_rst", 64'(m_req), 0);
    chk("t5_d_rdata_rst", d_rdata, 0);
    chk("t5_b_rd_forced", 64'(b_rd), 0);
    m_ack = 1'b1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF; rst_n = 1'b1; d_rd = 1'b0;
    @(negedge clk);
    chk("t5_late_ack_d_rdata", d_rdata, 0);
    chk("t5_late_ack_m_req", 64'(m_req), 0);
    mem_auto = 1'b1;
    @(negedge clk);

    // Known load, then a spurious ack in idle.
    lat = 1;
    mem[64'h3010] = 64'h0A0B_0C0D_0E0F_1011;
    exp_req.push_back('{1, 64'h3010, 64'h0, 8'hFF});
    exp_ld.push_back(64'h0A0B_0C0D_0E0F_1011);
    d_rd = 1'b1; d_addr = 64'h3010;
    #1;
    for (int k = 0; k < 40 && b_rd; k++) @(negedge clk);
    chk("t6_load_done", 64'(b_rd), 0);
    d_rd = 1'b0;
    repeat (2) @(negedge clk);
    mem_auto = 1'b0;
    m_ack = 1'b1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("t6_spur_d_rdata", d_rdata, 64'h0A0B_0C0D_0E0F_1011);
    chk("t6_spur_if_data", 64'(if_data), 0);
    chk("t6_spur_m_req", 64'(m_req), 0);
    @(negedge clk);
    chk("t6_spur_m_req2", 64'(m_req), 0);
    mem_auto = 1'b1;

    // Load and store together: served as a store, load port follows.
    lat = 2;
    exp_req.push_back('{2, 64'h2008, 64'hCAFE_0000_1234_5678, 8'hF0});
    exp_ld.push_back(64'h0A0B_0C0D_0E0F_1011);
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 64'h2008; d_be = 8'hF0; d_wdata = 64'hCAFE_0000_1234_5678;
    #1;
    chk("t7_b_rd_busy", 64'(b_rd), 1);
    chk("t7_b_wr_busy", 64'(b_wr), 1);
    for (int k = 0; k < 40 && b_wr; k++) @(negedge clk);
    chk("t7_b_wr_done", 64'(b_wr), 0);
    chk("t7_b_rd_done", 64'(b_rd), 0);
    d_rd = 1'b0; d_wr = 1'b0;
    repeat (3) @(negedge clk);

    chk("end_exp_req_empty", 64'(exp_req.size()), 0);
    chk("end_exp_if_empty", 64'(exp_if.size()), 0);
    chk("end_exp_ld_empty", 64'(exp_ld.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/biu.md
BIU -- requirements
Module: biu

Interface
REQ-001 Parameter XLEN, 64, address and data-port width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 if_rd  in  1  fetch request, level, held until b_rd_i low.
REQ-005 if_addr  in  XLEN  fetch address.
REQ-006 if_data  out  32  fetched instruction, registered, held until next fetch completion.
REQ-007 b_rd_i  out  1  fetch busy, to control unit.
REQ-008 d_rd  in  1  load request, level.
REQ-009 d_wr  in  1  store request, level.
REQ-010 d_addr  in  XLEN  load/store address.
REQ-011 d_wdata  in  XLEN  store data.
REQ-012 d_be  in  XLEN/8  store byte enables.
REQ-013 d_rdata  out  XLEN  load data, registered, held until next load completion.
REQ-014 b_rd  out  1  load busy.
REQ-015 b_wr  out  1  store busy.
REQ-016 m_req, m_we  out  1 each  memory request and write strobe.
REQ-017 m_addr, m_wdata, m_be  out  XLEN, XLEN, XLEN/8  memory request payload.
REQ-018 m_ack  in  1  single-cycle completion pulse.
REQ-019 m_rdata  in  XLEN  read data, valid only with m_ack.

Function
REQ-020 FSM states IDLE, FETCH, LOAD, STORE; one memory transaction outstanding at most.
REQ-021 IDLE arbitration: pending store or load beats pending fetch; pending = request high and port done flag clear.
REQ-022 On leaving IDLE: m_req, m_we, m_addr, m_wdata, m_be registered high/valid the next cycle, held stable until m_ack sampled.
REQ-023 FETCH: m_addr = if_addr with low 3 bits cleared; if_data = m_rdata word selected by if_addr[2].
REQ-024 LOAD/STORE: m_addr = d_addr; m_be = d_be for store, all ones for load; m_we high only in STORE.
REQ-025 On m_ack: capture read data, set port done flag, drop m_req at same edge, return to IDLE.
REQ-026 m_ack while m_req low: ignored.
REQ-027 b_rd_i = if_rd & ~done_i; b_rd = d_rd & ~done_d; b_wr = d_wr & ~done_d; combinational, no registered delay.
REQ-028 Done flags clear at the first edge where b_rd_i, b_rd, b_wr are all 0 (pipeline advanced).
REQ-029 A fetch held by a hazard stall after flag clear is re-issued; harmless re-read, accepted.
REQ-030 Zero-wait memory (m_ack in first m_req cycle): request at cycle t, busy low at t+2.
REQ-031 d_rd and d_wr both high: illegal; served as store, b_rd mirrors b_wr.
REQ-032 Request dropped mid-transaction: transaction still completes; result captured, no busy impact.

Reset
REQ-033 rst_n low at an edge: state IDLE, m_req 0, m_we 0, done flags 0, if_data 0, d_rdata 0.
REQ-034 While rst_n low: b_rd_i, b_rd, b_wr forced 0.
REQ-035 Reset mid-transaction abandons it; later m_ack ignored; memory tolerates abandoned request.

Structure
REQ-036 Shared package holds XLEN and FSM state encoding.
REQ-037 No sub-module; single flat block.

Verification
REQ-038 Fetch, zero-wait: if_rd=1, if_addr=0x1004, m_rdata=0xAAAA_BBBB_0000_0013 -> m_req cycle 1, b_rd_i low cycle 2, if_data=0xAAAABBBB.
REQ-039 Simultaneous fetch and load, 3-cycle memory latency -> load served first, fetch follows; b_rd low before b_rd_i.
REQ-040 Store, d_addr=0x2000, d_be=0x0F, d_wdata=0x1122334455667788 -> m_we=1, m_be=0x0F, payload stable until ack, b_wr low next cycle.
REQ-041 Fetch done while load busy -> no fetch re-issue until all busy low for one cycle.
REQ-042 rst_n low during LOAD with ack due next cycle -> m_req 0 after edge, d_rdata 0, late ack ignored.
REQ-043 Spurious m_ack in IDLE -> no state, flag, or data change.
